// File: rtl/fifo_drain_ctrl_pkg.sv
// fifo_ctrl_pkg: shared drain-controller types and defaults
package fifo_ctrl_pkg;
  localparam int STATE_W = 3;
  localparam int DEF_DATA_WIDTH = 8;
  typedef enum logic [STATE_W-1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE, GAP} state_t;
endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if: FIFO read port + serializer VALID/BUSY handshake bundle
// master = drain controller (drives fifo_r_inc, tx_data, tx_data_valid)
// slave  = FIFO/serializer side (drives fifo_empty, fifo_rd_data, tx_busy)
interface fifo_drain_ctrl_if import fifo_ctrl_pkg::*; #(parameter int DATA_WIDTH = DEF_DATA_WIDTH);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_r_inc;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  modport master(input fifo_empty, fifo_rd_data, tx_busy, output fifo_r_inc, tx_data, tx_data_valid);
  modport slave(output fifo_empty, fifo_rd_data, tx_busy, input fifo_r_inc, tx_data, tx_data_valid);
endinterface

// File: rtl/fifo_drain_ctrl_gap_timer.sv
// drain_gap_timer: down-counter that times the idle gap after a full burst
// i_load: arm with GAP_CYCLES; i_count: advance one step; o_expired: last gap cycle reached
module drain_gap_timer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] r_cnt;
  // loaded with GAP_CYCLES-1 so expiry lands on the GAP_CYCLES-th gap cycle
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else r_cnt <= i_load ? GW'(GAP_CYCLES - 1) : (i_count && r_cnt != '0) ? r_cnt - GW'(1) : r_cnt;
  assign o_expired = r_cnt == '0;
endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops FIFO words and hands them one at a time to a serializer, with burst gaps
// clk/rst: read-domain clock, sync active-high reset; i_en: drain enable
// drain: FIFO read port + serializer handshake; o_ctrl_busy: not IDLE; o_words_sent: wrapping hand-off count
module fifo_drain_ctrl import fifo_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = 16,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  fifo_drain_ctrl_if.master    drain,
  output logic                 o_ctrl_busy,
  output logic [CNT_WIDTH-1:0] o_words_sent
);
  localparam int BW = $clog2(BURST_MAX + 1);
  state_t                r_state, w_next;
  logic [BW-1:0]         r_burst;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_words;
  logic                  w_take, w_ack, w_done, w_full, w_gap_load, w_gap_done;
  assign w_take     = r_state == IDLE && i_en && !drain.fifo_empty && !drain.tx_busy;
  assign w_ack      = r_state == WAIT_ACK && drain.tx_busy;
  assign w_done     = r_state == WAIT_DONE && !drain.tx_busy;
  assign w_full     = r_burst == BW'(BURST_MAX);
  assign w_gap_load = w_done && w_full;
  drain_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_gap_load),
    .i_count  (r_state == GAP),
    .o_expired(w_gap_done)
  );
  always_comb begin
    w_next = w_take                        ? LOAD      :
             r_state == LOAD               ? WAIT_ACK  :
             w_ack                         ? WAIT_DONE :
             w_done                        ? (w_full ? GAP : IDLE) :
             (r_state == GAP && w_gap_done) ? IDLE      : r_state;
    drain.fifo_r_inc    = r_state == LOAD;
    drain.tx_data_valid = r_state == LOAD || r_state == WAIT_ACK;
    drain.tx_data       = r_data;
    o_ctrl_busy         = r_state != IDLE;
    o_words_sent        = r_words;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_burst <= '0;
      r_data  <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) r_data <= drain.fifo_rd_data;
      if (w_ack) r_words <= r_words + CNT_WIDTH'(1);
      // a disabled IDLE restarts the burst, so resumed draining gets a full burst
      r_burst <= ((r_state == IDLE && !i_en) || w_gap_load) ? '0 : w_ack ? r_burst + BW'(1) : r_burst;
    end
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed self-checking bench for fifo_drain_ctrl
module tb_fifo_drain_ctrl;
  logic       clk = 0, rst = 1, en = 0;
  logic       ctrl_busy;
  logic [3:0] words_sent;
  logic [7:0] q[$];
  logic [7:0] sent[$];
  logic [7:0] vdata;
  int n_checks = 0, n_errors = 0;
  int delay = 1, hold = 3;
  int pops = 0, busy_cyc = 0, gap_cyc = 0, vrun = 0, last_vlen = 0, unstable = 0, bad_pops = 0;
  always #5 clk = ~clk;
  fifo_drain_ctrl_if #(.DATA_WIDTH(8)) bus();
  fifo_drain_ctrl #(.DATA_WIDTH(8), .BURST_MAX(4), .GAP_CYCLES(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_en(en), .drain(bus), .o_ctrl_busy(ctrl_busy), .o_words_sent(words_sent)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic drive_en(input logic v);
    @(negedge clk);
    en = v;
  endtask
  task automatic push(input logic [7:0] w);
    q.push_back(w);
  endtask
  function automatic logic [31:0] last_sent();
    return sent.size() == 0 ? 32'hFFFF_FFFF : {24'h0, sent[sent.size()-1]};
  endfunction
  task automatic wait_drained(input string tag);
    int n = 0;
    while (!(q.size() == 0 && !bus.tx_busy && !ctrl_busy) && n < 3000) begin
      cycles(1);
      n++;
    end
    check(tag, n < 3000, 1);
  endtask
  // FIFO and serializer model: BUSY rises once VALID has been seen for delay+1 negedges, held hold cycles
  initial begin
    int vcnt = 0, left = 0;
    bus.tx_busy = 0;
    bus.fifo_empty = 1;
    bus.fifo_rd_data = 0;
    forever begin
      @(negedge clk);
      if (bus.fifo_r_inc && q.size() > 0) void'(q.pop_front());
      if (bus.tx_busy) begin
        left--;
        if (left <= 0) bus.tx_busy = 0;
      end else if (bus.tx_data_valid) begin
        vcnt++;
        if (vcnt == delay + 1) begin
          bus.tx_busy = 1;
          left = hold;
          vcnt = 0;
          sent.push_back(bus.tx_data);
        end
      end else vcnt = 0;
      bus.fifo_empty = q.size() == 0;
      bus.fifo_rd_data = q.size() == 0 ? 8'h00 : q[0];
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.fifo_r_inc) pops++;
      if (bus.fifo_r_inc && q.size() == 0) bad_pops++;
      if (ctrl_busy) busy_cyc++;
      if (ctrl_busy && !bus.tx_data_valid && !bus.tx_busy) gap_cyc++;
      if (bus.tx_data_valid) begin
        if (vrun == 0) vdata = bus.tx_data;
        else if (bus.tx_data != vdata) unstable++;
        vrun++;
        last_vlen = vrun;
      end else vrun = 0;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int p, g, b, u, n, pr;
    cycles(3);
    check("rst_r_inc", bus.fifo_r_inc, 0);
    check("rst_valid", bus.tx_data_valid, 0);
    check("rst_data", bus.tx_data, 0);
    check("rst_busy", ctrl_busy, 0);
    check("rst_words", words_sent, 0);
    @(negedge clk) rst = 0;
    // single word, BUSY one cycle after VALID, held 10
    hold = 10;
    cycles(1);
    push(8'hA5);
    p = pops;
    drive_en(1);
    wait_drained("t1_drain");
    check("t1_pops", pops - p, 1);
    check("t1_data", bus.tx_data, 8'hA5);
    check("t1_sent", last_sent(), 8'hA5);
    check("t1_vlen", last_vlen, 2);
    check("t1_words", words_sent, 1);
    check("t1_idle", ctrl_busy, 0);
    drive_en(0);
    cycles(2);
    // empty FIFO with enable: nothing happens
    p = pops;
    b = busy_cyc;
    drive_en(1);
    cycles(50);
    check("t2_pops", pops - p, 0);
    check("t2_busy", busy_cyc - b, 0);
    drive_en(0);
    cycles(2);
    // six words: burst of 4, 3 gap cycles, then 2
    hold = 3;
    sent.delete();
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    p = pops;
    g = gap_cyc;
    drive_en(1);
    wait_drained("t3_drain");
    check("t3_pops", pops - p, 6);
    check("t3_gap", gap_cyc - g, 3);
    check("t3_words", words_sent, 7);
    check("t3_nsent", sent.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_word%0d", i), i < sent.size() ? {24'h0, sent[i]} : 32'hFFFF_FFFF, 32'h10 + 32'(i));
    drive_en(0);
    cycles(2);
    // slow serializer: VALID held 6 cycles with stable data
    delay = 5;
    push(8'h3C);
    p = pops;
    u = unstable;
    drive_en(1);
    wait_drained("t4_drain");
    check("t4_vlen", last_vlen, 6);
    check("t4_stable", unstable - u, 0);
    check("t4_pops", pops - p, 1);
    check("t4_sent", last_sent(), 8'h3C);
    check("t4_words", words_sent, 8);
    drive_en(0);
    cycles(2);
    delay = 1;
    // enable dropped during WAIT_ACK, then resumed with a fresh burst
    push(8'h51);
    push(8'h52);
    push(8'h53);
    p = pops;
    g = gap_cyc;
    drive_en(1);
    n = 0;
    while (!(bus.tx_data_valid && !bus.fifo_r_inc) && n < 100) begin
      cycles(1);
      n++;
    end
    check("t5_wait_ack", n < 100, 1);
    drive_en(0);
    cycles(30);
    check("t5_halt_pops", pops - p, 1);
    check("t5_halt_words", words_sent, 9);
    check("t5_halt_sent", last_sent(), 8'h51);
    check("t5_halt_idle", ctrl_busy, 0);
    check("t5_halt_left", q.size(), 2);
    push(8'h54);
    push(8'h55);
    drive_en(1);
    n = 0;
    while (pops - p < 5 && n < 500) begin
      cycles(1);
      n++;
    end
    check("t5_reach5", n < 500, 1);
    check("t5_no_early_gap", gap_cyc - g, 0);
    wait_drained("t5_drain");
    check("t5_gap", gap_cyc - g, 3);
    check("t5_pops", pops - p, 5);
    check("t5_words", words_sent, 13);
    check("t5_sent", last_sent(), 8'h55);
    // reset while in WAIT_DONE
    hold = 10;
    push(8'h61);
    push(8'h62);
    p = pops;
    n = 0;
    while (!(ctrl_busy && !bus.tx_data_valid && bus.tx_busy) && n < 100) begin
      cycles(1);
      n++;
    end
    check("t6_wait_done", n < 100, 1);
    check("t6_words_pre", words_sent, 14);
    check("t6_pops_pre", pops - p, 1);
    pr = pops;
    @(negedge clk) rst = 1;
    cycles(1);
    check("t6_r_inc", bus.fifo_r_inc, 0);
    check("t6_valid", bus.tx_data_valid, 0);
    check("t6_data", bus.tx_data, 0);
    check("t6_busy", ctrl_busy, 0);
    check("t6_words", words_sent, 0);
    check("t6_no_pop", pops - pr, 0);
    @(negedge clk) rst = 0;
    wait_drained("t6_drain");
    check("t6_after_words", words_sent, 1);
    check("t6_after_pops", pops - pr, 1);
    check("t6_after_sent", last_sent(), 8'h62);
    // counter wrap: 17 words since reset on a 4-bit counter
    hold = 2;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    p = pops;
    wait_drained("wrap_drain");
    check("wrap_words", words_sent, 1);
    check("wrap_pops", pops - p, 16);
    check("no_pop_when_empty", bad_pops, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
